bert_pattern_tx: RTL and testbench
==================================

# bert_pattern_tx

Transmit-side pattern source for the bit-error-ratio tester. On command it emits a burst: sync bytes first, then data bytes. The data is either a PRBS7 pattern or an incrementing counter. Bytes go out over a valid/ready byte stream to the link under test, whose far end feeds `test_control`. An optional error-injection feature corrupts selected bytes so the receiver's error counters can be checked end to end.

## Interface
- `SYNC_LEN`, default 4: number of sync bytes sent before the data bytes (1..255).
- `SYNC_BYTE`, default 8'hA5: value of each sync byte.
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  one-cycle request to begin a burst; acted on only in IDLE.
- `abort`  in  1  ends the burst in progress (SYNC or RUN state).
- `sel`  in  1  pattern select, latched at start: 1 = PRBS7, 0 = incrementing counter.
- `burst_len`  in  32  number of data bytes, latched at start; 0 = continuous until abort.
- `inj_req`  in  1  one-cycle request to corrupt the next data byte (see Configuration).
- `tx_ready`  in  1  downstream accepts the byte on this cycle.
- `tx_data`  out  8  byte being offered.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_sync`  out  1  the current `tx_data` is a sync byte.
- `busy`  out  1  high in SYNC and RUN.
- `done`  out  1  one-cycle pulse when a finite burst completes.
- `sent_count`  out  32  data bytes transferred in the current or last burst.
- `inj_count`  out  16  number of bytes corrupted since reset.

## Operation
- States: IDLE, SYNC, RUN, DONE.
- IDLE → SYNC on `start`. Entering SYNC:
  - latch `sel` and `burst_len`;
  - clear `sent_count` and the sync counter;
  - load the PRBS7 state with 7'h7F and the counter pattern with 8'h00.
- Transfer rule: a byte transfers when `tx_valid` and `tx_ready` are both high. While `tx_ready` is low, `tx_data`, `tx_valid` and `tx_sync` hold stable.
- SYNC:
  - `tx_data` = `SYNC_BYTE`, `tx_sync` = 1.
  - After `SYNC_LEN` transfers, go to RUN.
- RUN:
  - `tx_sync` = 0.
  - The pattern advances only on a transfer.
  - `sent_count` increments on each transfer and wraps modulo 2^32.
  - When latched `burst_len` ≠ 0 and the transfer is number `burst_len`, go to DONE.
- DONE: `done` = 1 and `tx_valid` = 0 for one cycle, then IDLE.
- PRBS7:
  - Polynomial x^7+x^6+1, state s[6:0].
  - Per bit: fb = s[6]^s[5], then s ← {s[5:0], fb}; the output bit is fb.
  - Eight steps make one byte; the first bit generated is bit 7.
  - From seed 7'h7F the first data byte is 8'h02 and the second is 8'h0C.
- Counter pattern: 8'h00, 8'h01, … and wraps from 8'hFF to 8'h00.
- `abort` in SYNC or RUN: go to IDLE the next cycle and drop `tx_valid`. No `done` pulse. `sent_count` keeps its value, including any transfer made in the abort cycle.
- `start` while not in IDLE is ignored.
- `start` and `abort` in the same cycle while in IDLE: `abort` wins and the block stays in IDLE.
- `reset` in any state: IDLE next edge.

## Timing
- Every output is registered.
- Reset values: `tx_data` = 0, `tx_valid` = 0, `tx_sync` = 0, `busy` = 0, `done` = 0, `sent_count` = 0, `inj_count` = 0.
- `start` sampled at edge N: `tx_valid` = 1 with the first sync byte and `busy` = 1 from N+1.
- With `tx_ready` held high, one byte transfers per cycle, and the first data byte appears at N+1+`SYNC_LEN`.
- Last data transfer at edge M: `done` = 1 and `busy` = 0 during M+1; IDLE at M+2. A new `start` is accepted from M+2.
- `abort` sampled at edge A: `tx_valid` = 0 and `busy` = 0 from A+1.

## Configuration
- Macro: `BERT_ERR_INJECT_EN`.
- Defined:
  - `inj_req` sets a pending flag; the flag stays set until used.
  - The next data byte to transfer in RUN has bit 0 inverted on `tx_data`. The pattern sequence itself is unaffected.
  - The flag clears on that transfer and `inj_count` increments, saturating at 16'hFFFF.
  - Sync bytes are never corrupted.
  - If `inj_req` arrives while the flag is already pending, the requests merge into one.
- Undefined:
  - The `inj_req` port exists but is ignored.
  - `inj_count` is tied to 0.
  - No injection logic is synthesised.

## Structure
- Package `bert_pkg` holds:
  - the state enum `bert_tx_state_t`;
  - `PRBS7_SEED` = 7'h7F;
  - the tap positions 6 and 5;
  - the default `SYNC_BYTE` = 8'hA5.
- The receiver checker shares the same package.
- Sub-module `prbs7_byte_step`: combinational; takes s[6:0] and returns the next s plus the 8-bit output byte. The receiver reuses it.

## Test plan
- Reset, then `start` with `sel`=1, `burst_len`=3, `SYNC_LEN`=4, `tx_ready`=1 → A5, A5, A5, A5, 02, 0C, then the third PRBS byte with `tx_sync`=1 only on the A5 bytes; then `done` for one cycle and `sent_count`=3.
- `sel`=0, `burst_len`=258 → data bytes run 00..FF, 00, 01; `sent_count`=258.
- `tx_ready` toggling 1,0,0,1 during RUN → `tx_data` holds across the stall cycles, no byte skipped or repeated, and `sent_count` increments only on transfer cycles.
- `burst_len`=0 with `abort` after 10 data transfers → `tx_valid` drops on the next cycle, no `done`, `sent_count`=10; a following `start` restarts from A5 with the first data byte 02.
- `start` during RUN and `start`+`abort` in IDLE → both have no effect; `reset` mid-RUN → all outputs 0 the next cycle.
- With `BERT_ERR_INJECT_EN`, `inj_req` during SYNC → the first data byte is 8'h03 instead of 02, the second is 0C, and `inj_count`=1. Without the macro → 02, 0C and `inj_count`=0.

Source files
------------

// File: rtl/bert_pattern_tx_pkg.sv
// Shared types and constants for the BERT transmitter and receiver checker.
package bert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_RUN,
        ST_DONE
    } bert_tx_state_t;

    localparam logic [6:0] PRBS7_SEED        = 7'h7F;
    localparam int         PRBS7_TAP_HI      = 6;
    localparam int         PRBS7_TAP_LO      = 5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/bert_pattern_tx_if.sv
// Byte stream from the pattern source to the link under test.
interface bert_pattern_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_sync;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_sync, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_sync, output tx_ready);

endinterface

// File: rtl/bert_pattern_tx_prbs7_byte_step.sv
// Advances a PRBS7 (x^7+x^6+1) state by eight bits; the first bit produced lands in bit 7.
module prbs7_byte_step
    import bert_pkg::*;
(
    input  logic [6:0] state_i,
    output logic [6:0] state_o,
    output logic [7:0] byte_o
);

    logic [6:0] s;
    logic       fb;

    always_comb begin
        s      = state_i;
        fb     = 1'b0;
        byte_o = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            fb        = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
            s         = {s[5:0], fb};
            byte_o[i] = fb;
        end
        state_o = s;
    end

endmodule

// File: rtl/bert_pattern_tx.sv
// BERT transmit pattern source: sync bytes then PRBS7 or counter data bursts.
// Optional error injection is enabled by defining BERT_ERR_INJECT_EN.
module bert_pattern_tx
    import bert_pkg::*;
#(
    parameter int unsigned SYNC_LEN  = 4,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      sel,
    input  logic [31:0]               burst_len,
    input  logic                      inj_req,
    bert_pattern_tx_if.master         tx,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               sent_count,
    output logic [15:0]               inj_count
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

    bert_tx_state_t state_q;
    logic           sel_q;
    logic [31:0]    burst_len_q;
    logic [7:0]     sync_cnt_q;
    logic [6:0]     prbs_q;
    logic [6:0]     prbs_d;
    logic [7:0]     prbs_byte;
    logic [7:0]     cnt_q;
    logic [7:0]     tx_data_q;
    logic           tx_valid_q;
    logic           tx_sync_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    sent_count_q;

    logic           xfer;
    logic           sync_done;
    logic           run_xfer;
    logic           run_last;
    logic           load_data;
    logic           flip;
    logic [7:0]     data_byte;

    prbs7_byte_step u_prbs (
        .state_i (prbs_q),
        .state_o (prbs_d),
        .byte_o  (prbs_byte)
    );

    assign xfer      = tx_valid_q & tx.tx_ready;
    assign sync_done = (state_q == ST_SYNC) & xfer & (sync_cnt_q == SYNC_LAST) & ~abort;
    assign run_xfer  = (state_q == ST_RUN) & xfer;
    assign run_last  = run_xfer & (burst_len_q != 32'd0) & ((sent_count_q + 32'd1) == burst_len_q);
    assign load_data = sync_done | (run_xfer & ~run_last & ~abort);
    assign data_byte = (sel_q ? prbs_byte : cnt_q) ^ {7'b0, flip};

`ifdef BERT_ERR_INJECT_EN
    logic        pend_q;
    logic        cur_inj_q;
    logic [15:0] inj_count_q;

    // A corrupted byte already on the bus absorbs any further request until it transfers.
    assign flip = ~cur_inj_q & (pend_q | inj_req);

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q      <= 1'b0;
            cur_inj_q   <= 1'b0;
            inj_count_q <= 16'h0000;
        end else begin
            if (run_xfer & cur_inj_q & (inj_count_q != 16'hFFFF))
                inj_count_q <= inj_count_q + 16'd1;
            if (load_data)
                cur_inj_q <= flip;
            else if (run_xfer | abort)
                cur_inj_q <= 1'b0;
            if (load_data & flip)
                pend_q <= 1'b1;
            else if (run_xfer & cur_inj_q)
                pend_q <= 1'b0;
            else if (inj_req)
                pend_q <= 1'b1;
        end
    end

    assign inj_count = inj_count_q;
`else
    logic unused_inj;
    assign unused_inj = inj_req;
    assign flip       = 1'b0;
    assign inj_count  = 16'h0000;
`endif

    // tx_data always holds the byte on offer; the next one is loaded only on a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            burst_len_q  <= 32'd0;
            sync_cnt_q   <= 8'd0;
            prbs_q       <= PRBS7_SEED;
            cnt_q        <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_sync_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sent_count_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start & ~abort) begin
                        state_q      <= ST_SYNC;
                        sel_q        <= sel;
                        burst_len_q  <= burst_len;
                        sent_count_q <= 32'd0;
                        sync_cnt_q   <= 8'd0;
                        prbs_q       <= PRBS7_SEED;
                        cnt_q        <= 8'h00;
                        tx_data_q    <= SYNC_BYTE;
                        tx_valid_q   <= 1'b1;
                        tx_sync_q    <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                        tx_sync_q  <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (sync_done) begin
                        state_q   <= ST_RUN;
                        tx_sync_q <= 1'b0;
                        tx_data_q <= data_byte;
                        prbs_q    <= prbs_d;
                        cnt_q     <= cnt_q + 8'd1;
                    end else if (xfer) begin
                        sync_cnt_q <= sync_cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (run_xfer)
                        sent_count_q <= sent_count_q + 32'd1;
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (run_last) begin
                        state_q    <= ST_DONE;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (load_data) begin
                        tx_data_q <= data_byte;
                        prbs_q    <= prbs_d;
                        cnt_q     <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_sync  = tx_sync_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sent_count  = sent_count_q;

endmodule

// File: tb/tb_bert_pattern_tx.sv
// Self-checking bench for bert_pattern_tx: table-driven bursts plus hand-written corner sequences.
module tb_bert_pattern_tx;

    localparam int SYNC_LEN = 4;
`ifdef BERT_ERR_INJECT_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    typedef struct packed {
        logic       sync;
        logic [7:0] data;
    } expByte_t;

    typedef struct {
        bit sel;
        int len;
        bit stall;
        int expSent;
        int expCycles;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        sel;
    logic [31:0] burstLen;
    logic        injReq;
    logic        busy;
    logic        done;
    logic [31:0] sentCount;
    logic [15:0] injCount;

    int checks    = 0;
    int failures  = 0;
    int dataXfers = 0;

    expByte_t expQ[$];

    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic       prevSync  = 1'b0;
    logic [7:0] prevData  = 8'h00;

    bert_pattern_tx_if txIf ();

    bert_pattern_tx #(.SYNC_LEN(SYNC_LEN), .SYNC_BYTE(8'hA5)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .sel        (sel),
        .burst_len  (burstLen),
        .inj_req    (injReq),
        .tx         (txIf.master),
        .busy       (busy),
        .done       (done),
        .sent_count (sentCount),
        .inj_count  (injCount)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushSync();
        for (int i = 0; i < SYNC_LEN; i++) expQ.push_back('{sync: 1'b1, data: 8'hA5});
    endtask

    // Reference pattern straight from the polynomial description, restarting from the seed.
    task automatic pushData(input bit selV, input int n);
        logic [6:0] s;
        logic [7:0] c;
        logic [7:0] b;
        logic       fb;
        s = 7'h7F;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (selV) begin
                b = 8'h00;
                for (int k = 7; k >= 0; k--) begin
                    fb   = s[6] ^ s[5];
                    s    = {s[5:0], fb};
                    b[k] = fb;
                end
                expQ.push_back('{sync: 1'b0, data: b});
            end else begin
                expQ.push_back('{sync: 1'b0, data: c});
                c = c + 8'd1;
            end
        end
    endtask

    task automatic applyStimulus(input bit selV, input logic [31:0] lenV);
        @(posedge clock); #1;
        start          = 1'b1;
        sel            = selV;
        burstLen       = lenV;
        txIf.tx_ready  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("valid_after_start", txIf.tx_valid, 1);
    endtask

    task automatic waitDone(input int expSent, input bit stall, input int expCycles);
        int c;
        bit seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 3000) begin
            @(posedge clock); #1;
            txIf.tx_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            @(negedge clock);
            if (done) seen = 1'b1;
            else c++;
        end
        checkOutput("done_seen", seen, 1);
        if (expCycles >= 0) checkOutput("done_latency", c, expCycles);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("valid_in_done", txIf.tx_valid, 0);
        checkOutput("sent_count", sentCount, expSent);
        checkOutput("queue_drained", expQ.size(), 0);
        @(posedge clock); #1;
        txIf.tx_ready = 1'b1;
        @(negedge clock);
        checkOutput("done_one_cycle", done, 0);
    endtask

    // Scoreboard: every transfer pops the next expected byte; stalled bytes must hold.
    always @(negedge clock) begin
        expByte_t e;
        if (prevValid && !prevReady && txIf.tx_valid)
            checkOutput("stall_hold", {txIf.tx_sync, txIf.tx_data}, {prevSync, prevData});
        if (txIf.tx_valid && txIf.tx_ready) begin
            checkOutput("byte_expected", (expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("tx_byte", {txIf.tx_sync, txIf.tx_data}, {e.sync, e.data});
                if (!e.sync) dataXfers++;
            end
        end
        prevValid = txIf.tx_valid;
        prevReady = txIf.tx_ready;
        prevSync  = txIf.tx_sync;
        prevData  = txIf.tx_data;
    end

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t vecs[4];
        int   guard;

        vecs[0] = '{sel: 1'b1, len: 3,   stall: 1'b0, expSent: 3,   expCycles: SYNC_LEN + 3 - 1};
        vecs[1] = '{sel: 1'b0, len: 258, stall: 1'b0, expSent: 258, expCycles: SYNC_LEN + 258 - 1};
        vecs[2] = '{sel: 1'b1, len: 12,  stall: 1'b1, expSent: 12,  expCycles: -1};
        vecs[3] = '{sel: 1'b0, len: 7,   stall: 1'b1, expSent: 7,   expCycles: -1};

        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        sel           = 1'b0;
        burstLen      = 32'd0;
        injReq        = 1'b0;
        txIf.tx_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_tx_data", txIf.tx_data, 0);
        checkOutput("rst_tx_valid", txIf.tx_valid, 0);
        checkOutput("rst_tx_sync", txIf.tx_sync, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sent_count", sentCount, 0);
        checkOutput("rst_inj_count", injCount, 0);

        for (int v = 0; v < 4; v++) begin
            pushSync();
            pushData(vecs[v].sel, vecs[v].len);
            applyStimulus(vecs[v].sel, vecs[v].len);
            waitDone(vecs[v].expSent, vecs[v].stall, vecs[v].expCycles);
        end

        // Continuous burst aborted right after the tenth data transfer.
        dataXfers = 0;
        pushSync();
        pushData(1'b1, 10);
        applyStimulus(1'b1, 32'd0);
        guard = 0;
        while (dataXfers < 10 && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        checkOutput("abort_reached", dataXfers, 10);
        abort         = 1'b1;
        txIf.tx_ready = 1'b0;
        @(posedge clock); #1;
        abort         = 1'b0;
        txIf.tx_ready = 1'b1;
        @(negedge clock);
        checkOutput("abort_valid", txIf.tx_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sent_count", sentCount, 10);
        checkOutput("abort_queue", expQ.size(), 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_no_done", done, 0);
            @(negedge clock);
        end

        // Restart after abort begins again from the seed.
        pushSync();
        expQ.push_back('{sync: 1'b0, data: 8'h02});
        expQ.push_back('{sync: 1'b0, data: 8'h0C});
        applyStimulus(1'b1, 32'd2);
        waitDone(2, 1'b0, SYNC_LEN + 2 - 1);

        // A start request during RUN must not disturb the burst.
        pushSync();
        pushData(1'b0, 20);
        applyStimulus(1'b0, 32'd20);
        repeat (6) @(posedge clock);
        #1;
        start    = 1'b1;
        sel      = 1'b1;
        burstLen = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        waitDone(20, 1'b0, -1);

        // start together with abort in IDLE: abort wins.
        @(posedge clock); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        checkOutput("start_abort_busy", busy, 0);
        checkOutput("start_abort_valid", txIf.tx_valid, 0);

        // Reset in the middle of a continuous burst.
        pushSync();
        pushData(1'b1, 30);
        applyStimulus(1'b1, 32'd0);
        repeat (8) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        expQ.delete();
        checkOutput("midrst_tx_data", txIf.tx_data, 0);
        checkOutput("midrst_tx_valid", txIf.tx_valid, 0);
        checkOutput("midrst_tx_sync", txIf.tx_sync, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_sent_count", sentCount, 0);
        checkOutput("midrst_inj_count", injCount, 0);

        // Injection request during SYNC corrupts only the first data byte when enabled.
        pushSync();
        pushData(1'b1, 3);
        expQ[SYNC_LEN].data = expQ[SYNC_LEN].data ^ {7'b0, INJ_ON};
        applyStimulus(1'b1, 32'd3);
        @(posedge clock); #1;
        injReq = 1'b1;
        @(posedge clock); #1;
        injReq = 1'b0;
        waitDone(3, 1'b0, -1);
        checkOutput("inj_count", injCount, {15'b0, INJ_ON});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
